fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port phase_fetch  input  1  fetch phase active, from StateMachine.
REQ-006 SHALL have port phase_writeback  input  1  writeback phase active, from StateMachine.
REQ-007 SHALL have port jump_state_wf  input  1  jump taken, from writeback.
REQ-008 SHALL have port regdata_for_pc  input  XLEN  jump target, from writeback.
REQ-009 SHALL have port imem_req  output  1  instruction memory request.
REQ-010 SHALL have port imem_addr  output  XLEN  instruction memory address.
REQ-011 SHALL have port imem_ack  input  1  instruction memory data valid.
REQ-012 SHALL have port imem_rdata  input  32  instruction memory read data.
REQ-013 SHALL have port pc_fd  output  XLEN  PC of the fetched instruction, to decode.
REQ-014 SHALL have port inst_fd  output  32  fetched instruction, to decode.
REQ-015 SHALL have port stall_fetch  output  1  fetch phase not complete, to StateMachine.
REQ-016 SHALL have port fetch_misalign_fd  output  1  misaligned fetch target flag.

Function
REQ-017 SHALL hold the PC in a register; pc_fd and imem_addr SHALL both equal that register.
REQ-018 SHALL load the PC on a cycle with phase_writeback=1 and jump_state_wf=1 with {regdata_for_pc[XLEN-1:1],1'b0}.
REQ-019 SHALL load the PC on a cycle with phase_writeback=1 and jump_state_wf=0 with PC+4, modulo 2^XLEN (wrap, no carry out).
REQ-020 SHALL leave the PC unchanged when phase_writeback=0.
REQ-021 SHALL implement FSM IDLE, BUSY, HOLD: IDLE->BUSY on phase_fetch=1 and phase_writeback=0; BUSY->HOLD on imem_ack=1; HOLD->IDLE on phase_fetch=0.
REQ-022 SHALL drive imem_req as a register, high exactly while in BUSY.
REQ-023 SHALL accept imem_ack only in BUSY; an ack in IDLE or HOLD SHALL be ignored.
REQ-024 SHALL capture imem_rdata into inst_fd on the accepted ack; inst_fd SHALL hold until the next accepted ack.
REQ-025 SHALL drive stall_fetch = phase_fetch AND (state != HOLD), combinationally.
REQ-026 SHALL give minimum latency from phase_fetch rise to stall_fetch=0 of 2 cycles, when ack arrives on the first BUSY cycle.
REQ-027 SHALL ignore phase_fetch while phase_writeback=1; the PC update takes priority and the fetch starts on the following cycle.
REQ-028 SHALL leave the PC unaffected by a PC update during BUSY; imem_addr SHALL remain stable until ack.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set: PC=RESET_VECTOR, state=IDLE, imem_req=0, inst_fd=32'h0000_0013, fetch_misalign_fd=0.
REQ-030 SHALL, on reset asserted mid-BUSY, abandon the transaction; any later ack SHALL be ignored per REQ-023.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on a jump target with bit1=1: load the PC, set fetch_misalign_fd, then complete the next fetch with no imem_req, going IDLE->HOLD directly with inst_fd=32'h0000_0013.
REQ-032 SHALL, with FETCH_MISALIGN_TRAP_EN defined, clear fetch_misalign_fd on the next PC load.
REQ-033 SHALL, without FETCH_MISALIGN_TRAP_EN, tie fetch_misalign_fd to 0 and treat bit1 of the target as an ordinary address bit.

Verification
REQ-034 SHALL cover: release reset, pulse phase_fetch, ack 1 cycle after req -> imem_addr=0, inst_fd=imem_rdata, stall_fetch low 2 cycles after phase_fetch rise.
REQ-035 SHALL cover: phase_writeback with jump_state_wf=1, regdata_for_pc=32'h0000_1235 -> PC=32'h0000_1234.
REQ-036 SHALL cover: PC=32'hFFFF_FFFC, phase_writeback with jump_state_wf=0 -> PC=32'h0000_0000.
REQ-037 SHALL cover: ack held off 5 cycles -> stall_fetch=1 and imem_req=1 for 5 cycles, imem_addr stable; spurious ack in HOLD does not change inst_fd.
REQ-038 SHALL cover: rst_n low during BUSY -> imem_req=0 immediately, PC=RESET_VECTOR; subsequent ack ignored.
REQ-039 SHALL cover, with FETCH_MISALIGN_TRAP_EN: jump to 32'h0000_0102 -> fetch_misalign_fd=1, no imem_req, inst_fd=32'h0000_0013; next writeback clears the flag.

Source files
------------

// File: rtl/fetch_pc.sv
// Fetch-stage PC register and single-outstanding instruction memory request FSM.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            phase_writeback,
  input  logic            jump_state_wf,
  input  logic [XLEN-1:0] regdata_for_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_fd,
  output logic [31:0]     inst_fd,
  output logic            stall_fetch,
  output logic            fetch_misalign_fd
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] jmp_tgt;
  logic            pc_load;
  logic            req_q, req_d;
  logic [31:0]     inst_q, inst_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    jmp_tgt = regdata_for_pc & LSB_MASK;
    // The address must not move under an outstanding request.
    pc_load = phase_writeback && (state_q != BUSY);

    if (pc_load) begin
      pc_d = jump_state_wf ? jmp_tgt : pc_q + XLEN'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_d = jump_state_wf && jmp_tgt[1];
`endif
    end

    case (state_q)
      IDLE: begin
        // Writeback has priority; the fetch starts once it drops.
        if (phase_fetch && !phase_writeback) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (mis_q) begin
            state_d = HOLD;
            inst_d  = NOP;
          end else
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          state_d = HOLD;
          inst_d  = imem_rdata;
        end
      end
      HOLD: begin
        if (!phase_fetch) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      inst_q  <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      inst_q  <= inst_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_fd       = pc_q;
  assign inst_fd     = inst_q;
  assign stall_fetch = phase_fetch && (state_q != HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign_fd = mis_q;
`else
  assign fetch_misalign_fd = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: reset, fetch handshake, jumps, wrap, hold-off, reset abort, misalign.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phase_fetch, phase_writeback, jump_state_wf;
  logic [31:0] regdata_for_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_fd;
  logic [31:0] inst_fd;
  logic        stall_fetch;
  logic        fetch_misalign_fd;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_pc #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .phase_fetch(phase_fetch), .phase_writeback(phase_writeback),
    .jump_state_wf(jump_state_wf), .regdata_for_pc(regdata_for_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_fd(pc_fd), .inst_fd(inst_fd),
    .stall_fetch(stall_fetch), .fetch_misalign_fd(fetch_misalign_fd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_wb(input logic jmp, input logic [31:0] tgt);
    phase_writeback = 1'b1; jump_state_wf = jmp; regdata_for_pc = tgt;
    tick();
    phase_writeback = 1'b0; jump_state_wf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phase_fetch = 0; phase_writeback = 0; jump_state_wf = 0;
    regdata_for_pc = '0; imem_ack = 0; imem_rdata = '0;
    tick(); tick();
    chk32("reset_pc", pc_fd, 32'h0);
    chk32("reset_req", {31'b0, imem_req}, 32'h0);
    chk32("reset_inst", inst_fd, 32'h0000_0013);
    chk32("reset_stall", {31'b0, stall_fetch}, 32'h0);
    chk32("reset_mis", {31'b0, fetch_misalign_fd}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_basic();
    phase_fetch = 1'b1;
    #1;
    chk32("basic_stall0", {31'b0, stall_fetch}, 32'h1);
    chk32("basic_req0", {31'b0, imem_req}, 32'h0);
    tick();
    chk32("basic_req1", {31'b0, imem_req}, 32'h1);
    chk32("basic_addr", imem_addr, 32'h0);
    chk32("basic_stall1", {31'b0, stall_fetch}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk32("basic_stall2", {31'b0, stall_fetch}, 32'h0);
    chk32("basic_req2", {31'b0, imem_req}, 32'h0);
    chk32("basic_inst", inst_fd, 32'hDEAD_BEEF);
    phase_fetch = 1'b0;
    tick();
  endtask

  task automatic test_jump();
    do_wb(1'b1, 32'h0000_1235);
    chk32("jump_pc", pc_fd, 32'h0000_1234);
    chk32("jump_addr", imem_addr, 32'h0000_1234);
    do_wb(1'b0, 32'h0);
    chk32("seq_pc", pc_fd, 32'h0000_1238);
    tick();
    chk32("idle_hold_pc", pc_fd, 32'h0000_1238);
  endtask

  task automatic test_wrap();
    do_wb(1'b1, 32'hFFFF_FFFC);
    chk32("wrap_pre", pc_fd, 32'hFFFF_FFFC);
    do_wb(1'b0, 32'h0);
    chk32("wrap_pc", pc_fd, 32'h0000_0000);
  endtask

  task automatic test_priority();
    phase_fetch = 1'b1; phase_writeback = 1'b1; jump_state_wf = 1'b1;
    regdata_for_pc = 32'h0000_0200;
    tick();
    phase_writeback = 1'b0; jump_state_wf = 1'b0;
    chk32("prio_pc", pc_fd, 32'h0000_0200);
    chk32("prio_noreq", {31'b0, imem_req}, 32'h0);
    tick();
    chk32("prio_req", {31'b0, imem_req}, 32'h1);
    chk32("prio_addr", imem_addr, 32'h0000_0200);
    imem_ack = 1'b1; imem_rdata = 32'h0000_1111;
    tick();
    imem_ack = 1'b0; phase_fetch = 1'b0;
    chk32("prio_inst", inst_fd, 32'h0000_1111);
    tick();
  endtask

  task automatic test_holdoff();
    phase_fetch = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk32($sformatf("hold_req%0d", i), {31'b0, imem_req}, 32'h1);
      chk32($sformatf("hold_stall%0d", i), {31'b0, stall_fetch}, 32'h1);
      chk32($sformatf("hold_addr%0d", i), imem_addr, 32'h0000_0200);
      if (i == 2) begin
        phase_writeback = 1'b1; jump_state_wf = 1'b1; regdata_for_pc = 32'h0000_0800;
      end
      tick();
      phase_writeback = 1'b0; jump_state_wf = 1'b0;
    end
    chk32("hold_addr_busy_wb", imem_addr, 32'h0000_0200);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
    tick();
    imem_rdata = 32'hBAD0_0002;
    chk32("hold_inst", inst_fd, 32'hCAFE_0001);
    tick();
    imem_ack = 1'b0;
    chk32("hold_spurious_inst", inst_fd, 32'hCAFE_0001);
    chk32("hold_spurious_stall", {31'b0, stall_fetch}, 32'h0);
    phase_fetch = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_ack = 1'b0;
    chk32("idle_ack_inst", inst_fd, 32'hCAFE_0001);
    chk32("idle_ack_req", {31'b0, imem_req}, 32'h0);
  endtask

  task automatic test_reset_busy();
    do_wb(1'b1, 32'h0000_0040);
    phase_fetch = 1'b1;
    tick();
    chk32("rb_req", {31'b0, imem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk32("rb_req_async", {31'b0, imem_req}, 32'h0);
    chk32("rb_pc", pc_fd, 32'h0);
    phase_fetch = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0004;
    tick();
    tick();
    imem_ack = 1'b0;
    chk32("rb_ack_inst", inst_fd, 32'h0000_0013);
    chk32("rb_ack_req", {31'b0, imem_req}, 32'h0);
  endtask

  task automatic test_misalign();
    do_wb(1'b1, 32'h0000_0102);
    chk32("mis_pc", pc_fd, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk32("mis_flag", {31'b0, fetch_misalign_fd}, 32'h1);
    phase_fetch = 1'b1;
    tick();
    chk32("mis_noreq", {31'b0, imem_req}, 32'h0);
    chk32("mis_stall", {31'b0, stall_fetch}, 32'h0);
    chk32("mis_inst", inst_fd, 32'h0000_0013);
    phase_fetch = 1'b0;
    tick();
    do_wb(1'b0, 32'h0);
    chk32("mis_clr", {31'b0, fetch_misalign_fd}, 32'h0);
    chk32("mis_pc2", pc_fd, 32'h0000_0106);
`else
    chk32("mis_flag_off", {31'b0, fetch_misalign_fd}, 32'h0);
    phase_fetch = 1'b1;
    tick();
    chk32("mis_req_off", {31'b0, imem_req}, 32'h1);
    chk32("mis_addr_off", imem_addr, 32'h0000_0102);
    imem_ack = 1'b1; imem_rdata = 32'h0000_2222;
    tick();
    imem_ack = 1'b0; phase_fetch = 1'b0;
    chk32("mis_inst_off", inst_fd, 32'h0000_2222);
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_jump();
    test_wrap();
    test_priority();
    test_holdoff();
    test_reset_busy();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
